alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32: datapath width of gr1, gr2, c, hi, lo; legal values 8..64, even.
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1: width of the iteration counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 i_valid  in  1  request present.
REQ-006 i_datain  in  32  MIPS instruction; opcode [31:26], shamt [10:6], func [5:0], imm [15:0].
REQ-007 gr1  in  WIDTH  rs operand.
REQ-008 gr2  in  WIDTH  rt operand.
REQ-009 o_ready  out  1  block can accept a request this cycle.
REQ-010 o_valid  out  1  result c/flags valid.
REQ-011 i_out_ready  in  1  consumer takes the result.
REQ-012 c  out  WIDTH  result.
REQ-013 flags  out  3  [2] zero, [1] overflow, [0] negative.
REQ-014 hi, lo  out  WIDTH each  architectural HI/LO registers.

Function
REQ-015 Accept SHALL occur only when i_valid && o_ready; operands and instruction are latched on accept.
REQ-016 FSM states IDLE, BUSY, DONE; o_ready SHALL be 1 only in IDLE.
REQ-017 IDLE->DONE on accept of a single-cycle op; IDLE->BUSY on accept of mult/multu/div/divu; BUSY->DONE when counter reaches WIDTH; DONE->IDLE when i_out_ready=1.
REQ-018 Single-cycle ops SHALL be add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav, mfhi, mflo (R-type), plus addi, addiu, andi, ori, xori, slti, sltiu, beq, bne, lw, sw.
REQ-019 Single-cycle result SHALL appear with o_valid=1 in the cycle after accept (latency 1).
REQ-020 addi, addiu, slti, sltiu, lw, sw SHALL sign-extend imm to WIDTH; andi, ori, xori SHALL zero-extend.
REQ-021 beq and bne SHALL compute c = gr1 - gr2; zero flag reports equality.
REQ-022 lw and sw SHALL compute c = gr1 + sext(imm).
REQ-023 sll, srl, sra shift gr2 by shamt; the v-forms shift gr2 by gr1[$clog2(WIDTH)-1:0].
REQ-024 overflow SHALL be set only for add, addi, sub on signed overflow; it is 0 for the unsigned forms.
REQ-025 zero = (c == 0); negative = c[WIDTH-1]; flags SHALL be registered with c.
REQ-026 multu/mult: shift-add over WIDTH cycles producing a 2*WIDTH product, hi = upper half, lo = lower half; mult operates on magnitudes and then applies the sign correction.
REQ-027 divu/div: restoring division over WIDTH cycles giving lo = quotient, hi = remainder; signed remainder takes the dividend's sign.
REQ-028 Divide by zero: lo = all ones, hi = gr1, overflow flag = 1, same latency.
REQ-029 For mult/div ops, c = lo and flags are computed from lo; o_valid SHALL assert WIDTH+1 cycles after accept.
REQ-030 hi/lo SHALL update only when a mult/div completes (BUSY->DONE), never partially during BUSY.
REQ-031 mfhi/mflo SHALL return the current hi/lo in c.
REQ-032 In DONE, c, flags and o_valid SHALL hold until i_out_ready=1; i_valid is ignored.
REQ-033 Unknown opcode/func SHALL complete as a single-cycle op with c = 0, flags = 3'b100.

Reset
REQ-034 rst SHALL force IDLE, o_valid = 0, o_ready = 1, c = 0, flags = 0, hi = 0, lo = 0, counter = 0.
REQ-035 rst asserted during BUSY or DONE SHALL abort the operation with no hi/lo update; accept is possible in the first cycle after rst deasserts.

Structure
REQ-036 Shared package alu_pkg SHALL hold the opcode/func constants, state enum, and flag bit indices.
REQ-037 One sub-module, alu_muldiv (iterative multiply/divide, start/done), is natural; the single-cycle datapath SHALL be combinational logic inside alu_mc.

Verification
REQ-038 add with gr1 = 0x80000001, gr2 = 0x80000001 -> c = 0x00000002, flags = 3'b010 one cycle after accept.
REQ-039 addi with imm = 0x8020, gr1 = 0x00000001 -> c = 0xFFFF8021, flags = 3'b001.
REQ-040 mult with gr1 = 0xFFFFFFFE (-2), gr2 = 0x00000003 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFFA, o_valid at cycle 33, o_ready = 0 in cycles 1..33.
REQ-041 div with gr1 = 7, gr2 = 0 -> lo = 0xFFFFFFFF, hi = 7, flags[1] = 1; a following mfhi returns 7.
REQ-042 sub result held with i_out_ready = 0 for 5 cycles -> c stable and o_valid = 1 throughout, i_valid pulses ignored.
REQ-043 rst pulsed at cycle 10 of a divu -> hi/lo stay 0, o_valid = 0, a new add accepted on the next cycle completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the multi-cycle ALU: MIPS opcode/func codes,
// FSM state encoding and flag bit positions.
package alu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned FLAG_W  = 3;

  // Flag bit positions inside the 3-bit flags bus.
  localparam int unsigned FLAG_ZERO = 2;
  localparam int unsigned FLAG_OVF  = 1;
  localparam int unsigned FLAG_NEG  = 0;

  // Primary opcodes.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes.
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for the four iterative R-type ops (func 0x18..0x1B).
  function automatic logic is_muldiv(input logic [INSTR_W-1:0] instr);
    return (instr[31:26] == OP_RTYPE) && (instr[5:2] == 4'b0110);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle of alu_mc.
//   slave : i_valid, i_datain, gr1, gr2, i_out_ready in; o_ready, o_valid, c, flags, hi, lo out
//   master: the mirror image, used by the requester.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
);
  logic             i_valid;
  logic [31:0]      i_datain;
  logic [WIDTH-1:0] gr1;
  logic [WIDTH-1:0] gr2;
  logic             o_ready;
  logic             o_valid;
  logic             i_out_ready;
  logic [WIDTH-1:0] c;
  logic [2:0]       flags;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport slave (
    input  i_valid, i_datain, gr1, gr2, i_out_ready,
    output o_ready, o_valid, c, flags, hi, lo
  );

  modport master (
    output i_valid, i_datain, gr1, gr2, i_out_ready,
    input  o_ready, o_valid, c, flags, hi, lo
  );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative multiply (shift-add) / divide (restoring), one bit per cycle.
//   clk, rst           : clock, synchronous active-high reset
//   i_start            : latch operands and begin (one-cycle pulse)
//   i_div, i_signed    : operation select
//   i_a, i_b           : rs / rt operands
//   o_done_c           : final iteration happens on this cycle's edge
//   o_hi_c, o_lo_c     : final hi/lo, valid while o_done_c
//   o_dz_c             : divide by zero
module alu_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_div,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done_c,
  output logic             o_dz_c,
  output logic [WIDTH-1:0] o_hi_c,
  output logic [WIDTH-1:0] o_lo_c
);

  logic             r_busy, r_div, r_neg_q, r_neg_r, r_dz;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a_raw, r_b, r_upper, r_lower;

  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_up_nxt, w_lo_nxt, w_q, w_r;
  logic [WIDTH:0]     w_msum, w_shift, w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [CNT_W-1:0]   w_cnt_nxt;

  assign w_a_mag   = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_b_mag   = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;
  assign w_cnt_nxt = r_cnt + CNT_W'(1);

  // One iteration; results are taken from the post-iteration values so the
  // top can capture them on the same edge as the last step.
  always_comb begin
    w_msum  = {1'b0, r_upper} + {1'b0, (r_lower[0] ? r_b : '0)};
    w_shift = {r_upper, r_lower[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_b};
    if (r_div) begin
      if (!w_diff[WIDTH]) begin
        w_up_nxt = w_diff[WIDTH-1:0];
        w_lo_nxt = {r_lower[WIDTH-2:0], 1'b1};
      end else begin
        w_up_nxt = w_shift[WIDTH-1:0];
        w_lo_nxt = {r_lower[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_up_nxt = w_msum[WIDTH:1];
      w_lo_nxt = {w_msum[0], r_lower[WIDTH-1:1]};
    end
    w_prod = {w_up_nxt, w_lo_nxt};
    if (r_neg_q) w_prod = -w_prod;
    w_q = r_neg_q ? -w_lo_nxt : w_lo_nxt;
    w_r = r_neg_r ? -w_up_nxt : w_up_nxt;
  end

  assign o_done_c = r_busy && (w_cnt_nxt == CNT_W'(WIDTH));
  assign o_dz_c   = r_div && r_dz;
  assign o_lo_c   = !r_div ? w_prod[WIDTH-1:0]     : (r_dz ? '1      : w_q);
  assign o_hi_c   = !r_div ? w_prod[2*WIDTH-1:WIDTH] : (r_dz ? r_a_raw : w_r);

  // Operand latch and iteration state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_cnt   <= '0;
      r_a_raw <= '0;
      r_b     <= '0;
      r_upper <= '0;
      r_lower <= '0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_div   <= i_div;
      r_dz    <= (i_b == '0);
      r_a_raw <= i_a;
      r_upper <= '0;
      // mult: multiplicand in r_b, multiplier shifts out of r_lower.
      // div: divisor in r_b, dividend shifts out of r_lower.
      r_b     <= i_div ? w_b_mag : w_a_mag;
      r_lower <= i_div ? w_a_mag : w_b_mag;
      r_neg_q <= i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      r_neg_r <= i_signed && i_div && i_a[WIDTH-1];
    end else if (r_busy) begin
      r_upper <= w_up_nxt;
      r_lower <= w_lo_nxt;
      r_cnt   <= o_done_c ? '0 : w_cnt_nxt;
      if (o_done_c) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle MIPS ALU: single-cycle ops resolve in one cycle, mult/div
// iterate WIDTH cycles in alu_muldiv and update HI/LO on completion.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_mc_if.slave request (i_valid/o_ready) and result
//              (o_valid/i_out_ready, c, flags, hi, lo)
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic   clk,
  input  logic   rst,
  alu_mc_if.slave bus
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  state_t              r_state;
  logic                r_ready, r_valid;
  logic [WIDTH-1:0]    r_c, r_hi, r_lo;
  logic [FLAG_W-1:0]   r_flags;

  logic [5:0]          w_op, w_fn;
  logic [4:0]          w_sh;
  logic [SH_W-1:0]     w_vsh;
  logic [15:0]         w_imm;
  logic [WIDTH-1:0]    w_sext, w_zext, w_sum_rr, w_dif_rr, w_sum_ri, w_res;
  logic                w_ovf, w_accept, w_is_md;
  logic [FLAG_W-1:0]   w_flags, w_md_flags;
  logic                w_md_done, w_md_dz;
  logic [WIDTH-1:0]    w_md_hi, w_md_lo;
  logic                w_unused_bits;

  assign w_op     = bus.i_datain[31:26];
  assign w_fn     = bus.i_datain[5:0];
  assign w_sh     = bus.i_datain[10:6];
  assign w_imm    = bus.i_datain[15:0];
  assign w_vsh    = bus.gr1[SH_W-1:0];
  assign w_sext   = WIDTH'($signed(w_imm));
  assign w_zext   = WIDTH'(w_imm);
  assign w_sum_rr = bus.gr1 + bus.gr2;
  assign w_dif_rr = bus.gr1 - bus.gr2;
  assign w_sum_ri = bus.gr1 + w_sext;
  assign w_accept = bus.i_valid && r_ready;
  assign w_is_md  = is_muldiv(bus.i_datain);
  assign w_unused_bits = ^bus.i_datain[25:16];

  // Single-cycle datapath; unknown encodings fall through to c = 0.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    if (w_op == OP_RTYPE) begin
      case (w_fn)
        FN_SLL:  w_res = bus.gr2 << w_sh;
        FN_SRL:  w_res = bus.gr2 >> w_sh;
        FN_SRA:  w_res = $signed(bus.gr2) >>> w_sh;
        FN_SLLV: w_res = bus.gr2 << w_vsh;
        FN_SRLV: w_res = bus.gr2 >> w_vsh;
        FN_SRAV: w_res = $signed(bus.gr2) >>> w_vsh;
        FN_MFHI: w_res = r_hi;
        FN_MFLO: w_res = r_lo;
        FN_ADD: begin
          w_res = w_sum_rr;
          w_ovf = (bus.gr1[WIDTH-1] == bus.gr2[WIDTH-1]) &&
                  (w_sum_rr[WIDTH-1] != bus.gr1[WIDTH-1]);
        end
        FN_ADDU: w_res = w_sum_rr;
        FN_SUB: begin
          w_res = w_dif_rr;
          w_ovf = (bus.gr1[WIDTH-1] != bus.gr2[WIDTH-1]) &&
                  (w_dif_rr[WIDTH-1] != bus.gr1[WIDTH-1]);
        end
        FN_SUBU: w_res = w_dif_rr;
        FN_AND:  w_res = bus.gr1 & bus.gr2;
        FN_OR:   w_res = bus.gr1 | bus.gr2;
        FN_XOR:  w_res = bus.gr1 ^ bus.gr2;
        FN_NOR:  w_res = ~(bus.gr1 | bus.gr2);
        FN_SLT:  w_res = WIDTH'($signed(bus.gr1) < $signed(bus.gr2));
        FN_SLTU: w_res = WIDTH'(bus.gr1 < bus.gr2);
        default: w_res = '0;
      endcase
    end else begin
      case (w_op)
        OP_BEQ, OP_BNE: w_res = w_dif_rr;
        OP_ADDI: begin
          w_res = w_sum_ri;
          w_ovf = (bus.gr1[WIDTH-1] == w_sext[WIDTH-1]) &&
                  (w_sum_ri[WIDTH-1] != bus.gr1[WIDTH-1]);
        end
        OP_ADDIU, OP_LW, OP_SW: w_res = w_sum_ri;
        OP_SLTI:  w_res = WIDTH'($signed(bus.gr1) < $signed(w_sext));
        OP_SLTIU: w_res = WIDTH'(bus.gr1 < w_sext);
        OP_ANDI:  w_res = bus.gr1 & w_zext;
        OP_ORI:   w_res = bus.gr1 | w_zext;
        OP_XORI:  w_res = bus.gr1 ^ w_zext;
        default:  w_res = '0;
      endcase
    end
  end

  always_comb begin
    w_flags               = '0;
    w_flags[FLAG_ZERO]    = (w_res == '0);
    w_flags[FLAG_OVF]     = w_ovf;
    w_flags[FLAG_NEG]     = w_res[WIDTH-1];
    w_md_flags            = '0;
    w_md_flags[FLAG_ZERO] = (w_md_lo == '0);
    w_md_flags[FLAG_OVF]  = w_md_dz;
    w_md_flags[FLAG_NEG]  = w_md_lo[WIDTH-1];
  end

  // func[1] selects divide, func[0] selects the unsigned form.
  alu_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_accept && w_is_md),
    .i_div    (w_fn[1]),
    .i_signed (!w_fn[0]),
    .i_a      (bus.gr1),
    .i_b      (bus.gr2),
    .o_done_c (w_md_done),
    .o_dz_c   (w_md_dz),
    .o_hi_c   (w_md_hi),
    .o_lo_c   (w_md_lo)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_c     <= '0;
      r_flags <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            if (w_is_md) begin
              r_state <= ST_BUSY;
            end else begin
              r_state <= ST_DONE;
              r_valid <= 1'b1;
              r_c     <= w_res;
              r_flags <= w_flags;
            end
          end
        end
        ST_BUSY: begin
          if (w_md_done) begin
            r_state <= ST_DONE;
            r_valid <= 1'b1;
            r_hi    <= w_md_hi;
            r_lo    <= w_md_lo;
            r_c     <= w_md_lo;
            r_flags <= w_md_flags;
          end
        end
        ST_DONE: begin
          if (bus.i_out_ready) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready = r_ready;
  assign bus.o_valid = r_valid;
  assign bus.c       = r_c;
  assign bus.flags   = r_flags;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;

endmodule
